// File: rtl/accel_pkg.sv
// Shared types and defaults for the accelerator tile datapath sequencing.
package accel_pkg;

  localparam int ADDR_W_DEF    = 15;
  localparam int OP_ADDR_W_DEF = 4;
  localparam int K_W_DEF       = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_WT = 3'd1,
    STREAM  = 3'd2,
    FLUSH   = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } seq_state_e;

  // Cycles needed for the last input row to ripple out of a skewed array.
  function automatic int flush_len(input int arr_size);
    return (2 * arr_size) - 1;
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Registered base+offset address generator with silent modulo-2^W wrap.
// The offset restarts on clear; each step presents base+offset and advances.
// On cycles without a step the address output rests at zero.
module seq_addr_gen #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] base,
  input  logic         clear,
  input  logic         step,
  output logic [W-1:0] addr
);

  logic [W-1:0] offset_r;
  logic [W-1:0] addr_r;

  // Offset tracking and registered address output.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_r <= {W{1'b0}};
      addr_r   <= {W{1'b0}};
    end else if (clear) begin
      offset_r <= {W{1'b0}};
      addr_r   <= {W{1'b0}};
    end else if (step) begin
      offset_r <= offset_r + {{(W-1){1'b0}}, 1'b1};
      addr_r   <= base + offset_r;
    end else begin
      addr_r   <= {W{1'b0}};
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/tile_sequencer.sv
// Sequences one tile through the systolic array: weight preload, input
// streaming, pipeline flush and accumulator drain. Every output is a flop
// loaded from the next-state/next-count decode, so a phase's first strobe
// appears in the cycle right after the transition into it.
module tile_sequencer
  import accel_pkg::*;
#(
  parameter int ARR_SIZE  = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int OP_ADDR_W = OP_ADDR_W_DEF,
  parameter int K_W       = K_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    wt_base,
  input  logic [ADDR_W-1:0]    inp_base,
  input  logic [OP_ADDR_W-1:0] op_base,
  input  logic [K_W-1:0]       k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 wt_rd_en,
  output logic [ADDR_W-1:0]    wt_addr,
  output logic                 inp_rd_en,
  output logic [ADDR_W-1:0]    inp_addr,
  output logic                 arr_load_wt,
  output logic                 arr_valid,
  output logic                 acc_clear,
  output logic                 acc_wr_en,
  output logic [OP_ADDR_W-1:0] acc_op_addr
);

  localparam int CLOG_W = $clog2(2 * ARR_SIZE);
  localparam int CNT_W  = (K_W > CLOG_W) ? K_W : CLOG_W;
  localparam logic [CNT_W-1:0] ARR_LAST   = CNT_W'(ARR_SIZE - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(flush_len(ARR_SIZE) - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  seq_state_e            state_r, state_next_s;
  logic [CNT_W-1:0]      cnt_r, cnt_next_s, k_last_s;
  logic [ADDR_W-1:0]     wt_base_r, inp_base_r, wt_base_sel_s;
  logic [OP_ADDR_W-1:0]  op_base_r;
  logic [K_W-1:0]        k_len_r;
  logic                  accept_s, reject_s, idle_next_s;
  logic                  busy_r, done_r, err_r;
  logic                  wt_rd_en_r, inp_rd_en_r, arr_load_wt_r, arr_valid_r;
  logic                  acc_clear_r, acc_wr_en_r;

  assign k_last_s      = CNT_W'(k_len_r) - CNT_W'(1);
  assign idle_next_s   = (state_next_s == IDLE);
  // In the accept cycle the weight base is not latched yet, so use the port.
  assign wt_base_sel_s = (state_r == IDLE) ? wt_base : wt_base_r;

  // Next-state and phase-counter decode; counter restarts on every transition.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r + CNT_W'(1);
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_next_s = CNT_ZERO;
        if (start) begin
          if (k_len != {K_W{1'b0}}) begin
            accept_s     = 1'b1;
            state_next_s = LOAD_WT;
          end else begin
            reject_s     = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD_WT: begin
        if (cnt_r == ARR_LAST) begin
          state_next_s = STREAM;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = LOAD_WT;
        end
      end
      STREAM: begin
        if (cnt_r == k_last_s) begin
          state_next_s = FLUSH;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = STREAM;
        end
      end
      FLUSH: begin
        if (cnt_r == FLUSH_LAST) begin
          state_next_s = DRAIN;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = FLUSH;
        end
      end
      DRAIN: begin
        if (cnt_r == ARR_LAST) begin
          state_next_s = DONE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and tile descriptor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      wt_base_r  <= {ADDR_W{1'b0}};
      inp_base_r <= {ADDR_W{1'b0}};
      op_base_r  <= {OP_ADDR_W{1'b0}};
      k_len_r    <= {K_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        wt_base_r  <= wt_base;
        inp_base_r <= inp_base;
        op_base_r  <= op_base;
        k_len_r    <= k_len;
      end
    end
  end

  // Registered strobes decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      wt_rd_en_r    <= 1'b0;
      arr_load_wt_r <= 1'b0;
      inp_rd_en_r   <= 1'b0;
      arr_valid_r   <= 1'b0;
      acc_clear_r   <= 1'b0;
      acc_wr_en_r   <= 1'b0;
    end else begin
      busy_r        <= !idle_next_s;
      done_r        <= (state_next_s == DONE);
      err_r         <= reject_s;
      wt_rd_en_r    <= (state_next_s == LOAD_WT);
      arr_load_wt_r <= (state_next_s == LOAD_WT);
      inp_rd_en_r   <= (state_next_s == STREAM);
      arr_valid_r   <= (state_next_s == STREAM);
      acc_clear_r   <= (state_next_s == LOAD_WT) && (cnt_next_s == CNT_ZERO);
      acc_wr_en_r   <= (state_next_s == DRAIN);
    end
  end

  seq_addr_gen #(.W(ADDR_W)) u_wt_addr (
    .clk   (clk),
    .reset (reset),
    .base  (wt_base_sel_s),
    .clear (idle_next_s),
    .step  (state_next_s == LOAD_WT),
    .addr  (wt_addr)
  );

  seq_addr_gen #(.W(ADDR_W)) u_inp_addr (
    .clk   (clk),
    .reset (reset),
    .base  (inp_base_r),
    .clear (idle_next_s),
    .step  (state_next_s == STREAM),
    .addr  (inp_addr)
  );

  seq_addr_gen #(.W(OP_ADDR_W)) u_op_addr (
    .clk   (clk),
    .reset (reset),
    .base  (op_base_r),
    .clear (idle_next_s),
    .step  (state_next_s == DRAIN),
    .addr  (acc_op_addr)
  );

  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign wt_rd_en    = wt_rd_en_r;
  assign arr_load_wt = arr_load_wt_r;
  assign inp_rd_en   = inp_rd_en_r;
  assign arr_valid   = arr_valid_r;
  assign acc_clear   = acc_clear_r;
  assign acc_wr_en   = acc_wr_en_r;

endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: launches push expected strobe events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_tile_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [14:0] wt_base = 15'd0;
  logic [14:0] inp_base = 15'd0;
  logic [3:0]  op_base = 4'd0;
  logic [15:0] k_len = 16'd0;
  logic        busy, done, err, wt_rd_en, inp_rd_en, arr_load_wt, arr_valid;
  logic        acc_clear, acc_wr_en;
  logic [14:0] wt_addr, inp_addr;
  logic [3:0]  acc_op_addr;

  tile_sequencer #(.ARR_SIZE(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .wt_base(wt_base), .inp_base(inp_base), .op_base(op_base), .k_len(k_len),
    .busy(busy), .done(done), .err(err),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr),
    .inp_rd_en(inp_rd_en), .inp_addr(inp_addr),
    .arr_load_wt(arr_load_wt), .arr_valid(arr_valid),
    .acc_clear(acc_clear), .acc_wr_en(acc_wr_en), .acc_op_addr(acc_op_addr)
  );

  always #5 clk = ~clk;

  // Event kinds: 0 wt read, 1 input read, 2 acc write, 3 acc clear, 4 done, 5 err
  typedef struct {
    int unsigned cyc;
    logic [14:0] addr;
  } ev_t;

  ev_t         evq [6][$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic        rst_q = 1'b1;
  int unsigned bfrom = 1, bto = 0, last_c0 = 0;
  logic [5:0]  mon_st;
  logic [14:0] mon_ad [3];
  bit          mon_exp;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic string sname(input int k);
    case (k)
      0: return "wt_rd_en";
      1: return "inp_rd_en";
      2: return "acc_wr_en";
      3: return "acc_clear";
      4: return "done";
      default: return "err";
    endcase
  endfunction

  task automatic push(input int k, input int unsigned c, input logic [14:0] a);
    ev_t e;
    e.cyc  = c;
    e.addr = a;
    evq[k].push_back(e);
  endtask

  // Drive one start pulse in the current cycle; if expect_acc, record the
  // hand-derived response: err next cycle for k==0, otherwise the full tile.
  task automatic launch(input logic [14:0] wb, input logic [14:0] ib, input logic [3:0] ob,
                        input logic [15:0] k, input bit expect_acc);
    int unsigned c0 = cyc;
    wt_base = wb; inp_base = ib; op_base = ob; k_len = k; start = 1'b1;
    if (expect_acc) begin
      if (k == 16'd0) begin
        push(5, c0 + 1, 15'd0);
      end else begin
        last_c0 = c0;
        push(3, c0 + 1, 15'd0);
        for (int i = 0; i < N; i++) push(0, c0 + 1 + i, wb + 15'(i));
        for (int j = 0; j < int'(k); j++) push(1, c0 + 1 + N + j, ib + 15'(j));
        for (int c = 0; c < N; c++) push(2, c0 + 3 * N + k + c, {11'd0, ob + 4'(c)});
        push(4, c0 + 4 * N + k, 15'd0);
        bfrom = c0 + 1;
        bto   = c0 + 4 * N + k;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compare every strobe/address against the scoreboard each cycle.
  always @(negedge clk) begin
    if (rst_q) begin
      chk("reset_strobes", {23'd0, busy, done, err, wt_rd_en, inp_rd_en, arr_load_wt,
                            arr_valid, acc_clear, acc_wr_en}, 32'd0);
      chk("reset_addrs", {2'd0, wt_addr, inp_addr}, 32'd0);
      chk("reset_op_addr", {28'd0, acc_op_addr}, 32'd0);
    end else begin
      mon_st    = {err, done, acc_clear, acc_wr_en, inp_rd_en, wt_rd_en};
      mon_ad[0] = wt_addr;
      mon_ad[1] = inp_addr;
      mon_ad[2] = {11'd0, acc_op_addr};
      for (int k = 0; k < 6; k++) begin
        mon_exp = (evq[k].size() != 0) && (evq[k][0].cyc == cyc);
        chk(sname(k), {31'd0, mon_st[k]}, {31'd0, mon_exp});
        if (k == 0) chk("arr_load_wt", {31'd0, arr_load_wt}, {31'd0, mon_exp});
        if (k == 1) chk("arr_valid", {31'd0, arr_valid}, {31'd0, mon_exp});
        if (mon_exp) begin
          if (k < 3) chk({sname(k), "_addr"}, {17'd0, mon_ad[k]}, {17'd0, evq[k][0].addr});
          void'(evq[k].pop_front());
        end
      end
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= bfrom) && (cyc <= bto)});
    end
  end

  initial begin
    int unsigned c;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic tile: done 19 cycles after the accepting cycle.
    launch(15'h0010, 15'h0100, 4'd2, 16'd3, 1'b1);
    wait_until(last_c0 + 21);

    // k_len==0 is rejected with a single err pulse.
    launch(15'h0055, 15'h0066, 4'd7, 16'd0, 1'b1);
    wait_until(cyc + 3);

    // Weight and output address wrap.
    launch(15'h7FFE, 15'h0000, 4'd14, 16'd2, 1'b1);
    wait_until(last_c0 + 4 * N + 2 + 2);

    // Starts during STREAM are ignored; back-to-back start right after done.
    launch(15'h0020, 15'h0200, 4'd0, 16'd5, 1'b1);
    c = last_c0;
    wait_until(c + 6);
    launch(15'h7000, 15'h7000, 4'd9, 16'd0, 1'b0);
    launch(15'h1234, 15'h4321, 4'd5, 16'd7, 1'b0);
    wait_until(c + 4 * N + 5 + 1);
    launch(15'h0030, 15'h0300, 4'd8, 16'd1, 1'b1);
    wait_until(last_c0 + 4 * N + 1 + 2);

    // Reset in the middle of STREAM, then a fresh tile straight after.
    launch(15'h0040, 15'h0400, 4'd3, 16'd4, 1'b1);
    c = last_c0;
    wait_until(c + 6);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) evq[k].delete();
    bto = cyc - 1;
    launch(15'h0040, 15'h0400, 4'd3, 16'd4, 1'b1);
    wait_until(last_c0 + 4 * N + 4 + 3);

    chk("queues_drained", evq[0].size() + evq[1].size() + evq[2].size() +
                          evq[3].size() + evq[4].size() + evq[5].size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Sequences one matrix tile through the systolic array datapath: weight preload, input streaming, pipeline flush, then drain of accumulator results into the output buffer.
- Sits between controller (issues start and tile descriptor) and weight buffer, input buffer, array and accumulator (receives strobes and addresses).
- Replaces ad-hoc sequencing in controller; controller only decodes instructions and launches tiles.

Parameters:
- ARR_SIZE, 4, array dimension (rows = cols); legal range 2..16.
- ADDR_W, 15, weight/input buffer address width.
- OP_ADDR_W, 4, output buffer / accumulator address width.
- K_W, 16, width of tile depth field.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle launch request from controller.
- wt_base  in  ADDR_W  first weight buffer row address.
- inp_base  in  ADDR_W  first input buffer row address.
- op_base  in  OP_ADDR_W  first output buffer address.
- k_len  in  K_W  number of input rows to stream (tile depth).
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle pulse in DONE state.
- err  out  1  one-cycle pulse when start is rejected for k_len==0.
- wt_rd_en  out  1  weight buffer read strobe.
- wt_addr  out  ADDR_W  weight buffer read address.
- inp_rd_en  out  1  input buffer read strobe.
- inp_addr  out  ADDR_W  input buffer read address.
- arr_load_wt  out  1  array latches weight row this cycle.
- arr_valid  out  1  array input row valid this cycle.
- acc_clear  out  1  accumulator clear pulse.
- acc_wr_en  out  1  accumulator writes column result to output buffer.
- acc_op_addr  out  OP_ADDR_W  output buffer address for that write.

Behaviour:
- Reset: state IDLE; counters 0; all outputs 0, including addresses. Reset mid-tile aborts immediately; no further strobes; a new start is accepted the cycle after reset deasserts.
- Start is sampled only in IDLE. If k_len==0: err pulses next cycle and the sequencer stays IDLE. If k_len!=0: base addresses and k_len are latched and the FSM enters LOAD_WT next cycle. start outside IDLE is ignored (no err).
- LOAD_WT: ARR_SIZE cycles. In cycle i (0-based): wt_rd_en=1, wt_addr=wt_base+i, arr_load_wt=1. acc_clear=1 only in cycle 0.
- STREAM: k_len cycles. In cycle j: inp_rd_en=1, inp_addr=inp_base+j, arr_valid=1.
- FLUSH: 2*ARR_SIZE-1 cycles with all strobes 0; covers skewed array latency.
- DRAIN: ARR_SIZE cycles. In cycle c: acc_wr_en=1, acc_op_addr=op_base+c.
- DONE: 1 cycle, done=1, busy=1; then IDLE.
- busy=0 in IDLE only.
- Total tile latency from the start-accept edge to the done pulse: 4*ARR_SIZE + k_len cycles.
- Address arithmetic is modulo 2^ADDR_W (buffer addresses) and modulo 2^OP_ADDR_W (output addresses); wrap is silent and legal.
- All outputs are registered and driven from the state/counter registers; no combinational path from any input to any output.
- Phase counter width is max(K_W, clog2(2*ARR_SIZE)). It resets to 0 on every state transition.

Decomposition:
- Shared package accel_pkg holds: the state enum (IDLE, LOAD_WT, STREAM, FLUSH, DRAIN, DONE), ADDR_W/OP_ADDR_W defaults, and the FLUSH length function (2*ARR_SIZE-1).
- One sub-module: seq_addr_gen. It takes a base address, a step enable and a clear, and produces a base+offset address with wrap. It is instantiated three times (weight, input, output addresses).

Test Plan:
- ARR_SIZE=4, wt_base=0x10, inp_base=0x100, op_base=2, k_len=3, start at cycle 0 -> LOAD_WT cycles 1-4 (wt_addr 0x10..0x13, acc_clear at cycle 1), STREAM cycles 5-7 (inp_addr 0x100..0x102), FLUSH cycles 8-14, DRAIN cycles 15-18 (acc_op_addr 2..5), done at cycle 19, busy low at cycle 20.
- start with k_len=0 -> err pulses at cycle 1; busy and all strobes stay 0.
- wt_base=0x7FFE, op_base=14, ARR_SIZE=4 -> wt_addr sequence 0x7FFE,0x7FFF,0x0000,0x0001 and acc_op_addr sequence 14,15,0,1.
- Second start asserted during STREAM -> ignored; exactly one done pulse per accepted start; back-to-back start in the cycle after done is accepted.
- reset asserted in STREAM cycle 2 -> next cycle all outputs 0 and state IDLE; new start completes with the full normal sequence.
- k_len=1 -> exactly one inp_rd_en and one arr_valid; done at cycle 4*4+1=17.
